// File: rtl/dec_sched.sv
// Scheduler in front of an inverse-cipher core: round-robin grant between two requesters,
// single-block issue, watchdog-bounded wait for completion, one-deep response buffer.
module dec_sched (
   input  logic         iClk,
   input  logic         iRstN,
   input  logic         iReqValidA,
   input  logic [127:0] iReqDataA,
   output logic         oReqReadyA,
   input  logic         iReqValidB,
   input  logic [127:0] iReqDataB,
   output logic         oReqReadyB,
   output logic         oRspValid,
   input  logic         iRspReady,
   output logic [127:0] oRspData,
   output logic         oRspId,
   output logic         oCoreStart,
   output logic [127:0] oCoreData,
   input  logic         iCoreBlkEnd,
   input  logic [127:0] iCoreData,
   input  logic [10:0]  iKeyRoundReady,
   output logic         oBusy,
   output logic         oTimeout,
   output logic [15:0]  oBlkCount,
   output logic [1:0]   oDbgState
);

   // Handshakes: a request moves when iReqValidX & oReqReadyX in the same cycle (ready is a
   // one-cycle pulse from IDLE); a response moves when oRspValid & iRspReady.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_CAPT  = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [4:0]   wd_q, wd_d;
   logic         last_b_q, last_b_d;
   logic         pend_id_q, pend_id_d;
   logic [127:0] core_data_q, core_data_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [127:0] rsp_data_q, rsp_data_d;
   logic         rsp_id_q, rsp_id_d;
   logic [15:0]  blk_cnt_q, blk_cnt_d;
   logic         timeout_q, timeout_d;
   logic         can_issue, grant_a, grant_b;
   logic         key_unused;

   // Only the full-schedule flag gates issue; the per-round flags are informational.
   assign key_unused = ^iKeyRoundReady[9:0];

   always_comb begin
      state_d     = state_q;
      wd_d        = wd_q;
      last_b_d    = last_b_q;
      pend_id_d   = pend_id_q;
      core_data_d = core_data_q;
      rsp_valid_d = rsp_valid_q & ~iRspReady;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      blk_cnt_d   = blk_cnt_q;
      timeout_d   = 1'b0;
      oReqReadyA  = 1'b0;
      oReqReadyB  = 1'b0;
      oCoreStart  = 1'b0;

      can_issue = iKeyRoundReady[10] && (iReqValidA || iReqValidB) &&
                  (!rsp_valid_q || iRspReady);
      // On a tie the port that did not win last time goes first.
      grant_a   = iReqValidA && (!iReqValidB || last_b_q);
      grant_b   = iReqValidB && !grant_a;

      case (state_q)
         ST_IDLE: begin
            if (can_issue) begin
               oReqReadyA  = grant_a;
               oReqReadyB  = grant_b;
               core_data_d = grant_a ? iReqDataA : iReqDataB;
               pend_id_d   = grant_b;
               last_b_d    = grant_b;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Core is still idle here, so its end-of-block flag is meaningless this cycle.
            oCoreStart = 1'b1;
            wd_d       = 5'd0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            wd_d = wd_q + 5'd1;
            if (iCoreBlkEnd) begin
               state_d = ST_CAPT;
            end else if (wd_q == 5'd30) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_CAPT: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = iCoreData;
            rsp_id_d    = pend_id_q;
            blk_cnt_d   = blk_cnt_q + 16'd1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q     <= ST_IDLE;
         wd_q        <= 5'd0;
         last_b_q    <= 1'b1;
         pend_id_q   <= 1'b0;
         core_data_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
         blk_cnt_q   <= 16'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wd_q        <= wd_d;
         last_b_q    <= last_b_d;
         pend_id_q   <= pend_id_d;
         core_data_q <= core_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         blk_cnt_q   <= blk_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign oRspValid = rsp_valid_q;
   assign oRspData  = rsp_data_q;
   assign oRspId    = rsp_id_q;
   assign oCoreData = core_data_q;
   assign oBusy     = (state_q != ST_IDLE);
   assign oTimeout  = timeout_q;
   assign oBlkCount = blk_cnt_q;
   assign oDbgState = state_q;

endmodule

// File: tb/tb_dec_sched.sv
// Bench for dec_sched: behavioural core model, transaction-level reference with cycle
// accounting from the issue/response latencies, directed phases then random traffic.
module tb_dec_sched;

   localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         va, vb, ra, rb;
   logic [127:0] da, db;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [127:0] rsp_data;
   logic         core_start, core_end;
   logic [127:0] core_data_o, core_res;
   logic [10:0]  key_rdy;
   logic         busy, tmo;
   logic [15:0]  blk_cnt;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   dec_sched dut (
      .iClk(clk), .iRstN(rst_n),
      .iReqValidA(va), .iReqDataA(da), .oReqReadyA(ra),
      .iReqValidB(vb), .iReqDataB(db), .oReqReadyB(rb),
      .oRspValid(rsp_valid), .iRspReady(rsp_ready), .oRspData(rsp_data), .oRspId(rsp_id),
      .oCoreStart(core_start), .oCoreData(core_data_o),
      .iCoreBlkEnd(core_end), .iCoreData(core_res),
      .iKeyRoundReady(key_rdy), .oBusy(busy), .oTimeout(tmo),
      .oBlkCount(blk_cnt), .oDbgState(dbg_state)
   );

   // Stand-in for the inverse cipher: known-answer block decrypts properly, others are scrambled.
   function automatic logic [127:0] plain_of(input logic [127:0] ct);
      if (ct == KAT_CT) return KAT_PT;
      return {ct[63:0], ct[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Core model: end-of-block high when idle and on the final round; result the cycle after.
   int   core_cnt;
   int   core_lat = 12;
   bit   core_hang = 1'b0;
   logic core_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_busy <= 1'b0;
         core_cnt  <= 0;
         core_res  <= '0;
      end else if (core_start) begin
         core_busy <= 1'b1;
         core_cnt  <= 1;
      end else if (core_busy) begin
         if (!core_hang && core_cnt == core_lat) begin
            core_busy <= 1'b0;
            core_res  <= plain_of(core_data_o);
         end else begin
            core_cnt <= core_cnt + 1;
         end
      end
   end

   assign core_end = !core_hang && (!core_busy || core_cnt == core_lat);

   int n_cmp = 0;
   int n_bad = 0;
   int t = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
      end
   endtask

   // Stimulus knobs
   bit k_key, k_a, k_b, k_kat, k_hang;
   int k_rdy_mode, k_lat;
   // Driver state
   bit a_pend, b_pend, a_acc, b_acc;
   bit g_seq[$];

   // Reference model
   int           issue_at, free_at, to_at, cap_at;
   bit           m_rsp_valid, m_rsp_id, m_pend_id, m_last_b;
   logic [127:0] m_rsp_data, m_core_data;
   logic [15:0]  m_cnt;

   task automatic model_init();
      issue_at = -1; free_at = 0; to_at = -1; cap_at = -1;
      m_rsp_valid = 0; m_rsp_id = 0; m_pend_id = 0; m_last_b = 1;
      m_rsp_data = '0; m_core_data = '0; m_cnt = '0;
      core_hang = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      va = 0; vb = 0; a_pend = 0; b_pend = 0; a_acc = 0; b_acc = 0;
      #1;
      chk("rst_ready_a", ra, 0);
      chk("rst_ready_b", rb, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_data", core_data_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", tmo, 0);
      chk("rst_blk_count", blk_cnt, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_init();
   endtask

   task automatic step();
      bit go, ga, gb;
      @(posedge clk); #1;
      if (a_pend && a_acc) a_pend = 0;
      if (b_pend && b_acc) b_pend = 0;
      if (!a_pend && k_a) begin
         a_pend = 1;
         da = k_kat ? KAT_CT : rand128();
         k_kat = 0;
      end
      if (!b_pend && k_b) begin
         b_pend = 1;
         db = rand128();
      end
      va = a_pend;
      vb = b_pend;
      key_rdy = {k_key, 10'($urandom)};
      rsp_ready = (k_rdy_mode == 2) ? 1'($urandom_range(0, 1)) : k_rdy_mode[0];
      @(negedge clk);
      go = (t >= free_at) && k_key && (va || vb) && (!m_rsp_valid || rsp_ready);
      ga = go && va && (!vb || m_last_b);
      gb = go && vb && !ga;
      chk("ready_a", ra, ga);
      chk("ready_b", rb, gb);
      chk("core_start", core_start, t == issue_at);
      chk("busy", busy, (t >= issue_at) && (t < free_at));
      chk("timeout", tmo, t == to_at);
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid) begin
         chk("rsp_data", rsp_data, m_rsp_data);
         chk("rsp_id", rsp_id, m_rsp_id);
      end
      chk("blk_count", blk_cnt, m_cnt);
      chk("core_data", core_data_o, m_core_data);
      if (ra) g_seq.push_back(1'b0);
      if (rb) g_seq.push_back(1'b1);
      // Advance the reference by one cycle: consume first, a capture landing now wins.
      if (m_rsp_valid && rsp_ready) m_rsp_valid = 0;
      if (t + 1 == cap_at) begin
         m_rsp_valid = 1;
         m_rsp_data  = plain_of(m_core_data);
         m_rsp_id    = m_pend_id;
         m_cnt       = m_cnt + 16'd1;
      end
      if (ga || gb) begin
         m_core_data = ga ? da : db;
         m_pend_id   = gb;
         m_last_b    = gb;
         issue_at    = t + 1;
         core_lat    = k_lat;
         core_hang   = k_hang;
         if (k_hang) begin
            free_at = t + 33; to_at = t + 33; cap_at = -1;
         end else begin
            free_at = t + k_lat + 3; cap_at = free_at; to_at = -1;
         end
      end
      a_acc = ra && va;
      b_acc = rb && vb;
      t++;
   endtask

   initial begin
      va = 0; vb = 0; da = '0; db = '0; rsp_ready = 0; key_rdy = '0;
      k_key = 1; k_a = 0; k_b = 0; k_kat = 0; k_hang = 0; k_rdy_mode = 1; k_lat = 12;
      a_pend = 0; b_pend = 0; a_acc = 0; b_acc = 0;
      model_init();
      do_reset();

      // Known-answer block from A, response held so it can be inspected.
      k_a = 1; k_kat = 1; k_rdy_mode = 0; k_lat = 12;
      step();
      k_a = 0;
      repeat (19) step();
      chk("kat_pt", rsp_data, KAT_PT);
      chk("kat_id", rsp_id, 0);
      chk("kat_count", blk_cnt, 1);
      k_rdy_mode = 1;
      step();

      // Both requesters continuously valid: strict alternation, A first after reset.
      do_reset();
      g_seq.delete();
      k_a = 1; k_b = 1; k_rdy_mode = 1;
      repeat (80) begin
         k_lat = $urandom_range(1, 8);
         step();
      end
      if (g_seq.size() >= 4) begin
         chk("rr_g0", g_seq[0], 0);
         chk("rr_g1", g_seq[1], 1);
         chk("rr_g2", g_seq[2], 0);
         chk("rr_g3", g_seq[3], 1);
      end else begin
         chk("rr_grant_count", g_seq.size(), 4);
      end
      k_a = 0; k_b = 0;
      repeat (30) step();

      // Key schedule not ready: A waits, granted as soon as the flag rises.
      k_key = 0; k_a = 1;
      repeat (20) step();
      k_key = 1;
      step();
      k_a = 0;
      repeat (20) step();

      // Consumer stalls: no second grant, held data stable, then release.
      k_rdy_mode = 0; k_a = 1; k_lat = 6;
      repeat (50) step();
      k_rdy_mode = 1;
      repeat (30) step();
      k_a = 0;
      repeat (15) step();

      // Core never finishes: watchdog timeout, then a normal block.
      k_hang = 1; k_a = 1;
      step();
      k_hang = 0; k_a = 0;
      repeat (39) step();
      k_a = 1; k_lat = 9;
      step();
      k_a = 0;
      repeat (20) step();

      // Reset while waiting on the core.
      k_a = 1; k_lat = 20;
      repeat (5) step();
      k_a = 0;
      do_reset();
      repeat (40) step();

      // Random traffic.
      repeat (1500) begin
         k_key      = ($urandom_range(0, 7) != 0);
         k_a        = $urandom_range(0, 1);
         k_b        = $urandom_range(0, 1);
         k_rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
         k_lat      = $urandom_range(1, 20);
         k_hang     = ($urandom_range(0, 15) == 0);
         step();
      end
      k_a = 0; k_b = 0; k_key = 1; k_hang = 0; k_rdy_mode = 1;
      repeat (80) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
